// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for an in-place radix-2 FFT (bit-reversed load, compute, drain, natural-order unload).
// Define FFT_CTRL_CYCLE_COUNT_EN to build the compute+drain cycle counter; otherwise cycle_count is 0.
module fft_ctrl #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned LEVEL     = 9,
   parameter int unsigned PIPE_LAT  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load_we,
   output logic [LEVEL-1:0] load_addr,
   output logic             agu_rst_n,
   output logic             agu_enable,
   input  logic             agu_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEVEL-1:0] out_addr,
   output logic             out_bank,
   output logic             busy,
   output logic             done,
   output logic [15:0]      cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN,
      S_UNLOAD,
      S_DONE
   } state_e;

   localparam logic [LEVEL-1:0] CNT_LAST   = '1;
   localparam logic [LEVEL-1:0] DRAIN_LAST = (PIPE_LAT > 0) ? LEVEL'(PIPE_LAT - 1) : '0;

   // Elaboration-time guards on the configuration
   if (BIT_WIDTH < 1) begin : g_bad_bit_width
      $error("fft_ctrl: BIT_WIDTH must be at least 1");
   end
   if (LEVEL < 1 || LEVEL > 16) begin : g_bad_level
      $error("fft_ctrl: LEVEL must be in 1..16");
   end
   if (PIPE_LAT > (1 << LEVEL)) begin : g_bad_pipe_lat
      $error("fft_ctrl: PIPE_LAT must not exceed 2**LEVEL");
   end

   state_e           state_q, state_d;
   logic [LEVEL-1:0] cnt_q, cnt_d;
   logic [LEVEL-1:0] cnt_rev;
   logic             cnt_adv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_LOAD;
         S_LOAD:    if (in_valid && cnt_q == CNT_LAST) state_d = S_COMPUTE;
         S_COMPUTE: if (agu_done) state_d = (PIPE_LAT > 0) ? S_DRAIN : S_UNLOAD;
         S_DRAIN:   if (cnt_q == DRAIN_LAST) state_d = S_UNLOAD;
         S_UNLOAD:  if (out_ready && cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // One counter serves all phases; any state change restarts it from zero
   always_comb begin
      cnt_adv = ((state_q == S_LOAD) && in_valid) ||
                (state_q == S_DRAIN) ||
                ((state_q == S_UNLOAD) && out_ready);
      cnt_d   = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_adv) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      cnt_rev = '0;
      for (int unsigned i = 0; i < LEVEL; i++) begin
         cnt_rev[i] = cnt_q[LEVEL-1-i];
      end
   end

   always_comb begin
      in_ready   = (state_q == S_LOAD);
      load_we    = in_ready && in_valid;
      load_addr  = in_ready ? cnt_rev : '0;
      agu_rst_n  = (state_q == S_COMPUTE) || (state_q == S_DRAIN) || (state_q == S_UNLOAD);
      agu_enable = (state_q == S_COMPUTE);
      out_valid  = (state_q == S_UNLOAD);
      out_addr   = out_valid ? cnt_q : '0;
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
   end

   assign out_bank = 1'((LEVEL % 2) != 0);

`ifdef FFT_CTRL_CYCLE_COUNT_EN
   logic [15:0] cyc_q, cyc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   always_comb begin
      cyc_d = cyc_q;
      if ((state_q == S_LOAD) && (state_d == S_COMPUTE)) begin
         cyc_d = '0;
      end else if (((state_q == S_COMPUTE) || (state_q == S_DRAIN)) && (cyc_q != 16'hFFFF)) begin
         cyc_d = cyc_q + 16'd1;
      end
   end

   assign cycle_count = cyc_q;
`else
   assign cycle_count = '0;
`endif

endmodule
